muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameters SHALL be none; the datapath is fixed at 32 bits and register addresses at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1  input  32  operand A / dividend, read from the register file.
REQ-007 rs2  input  32  operand B / divisor, read from the register file.
REQ-008 rd_addr_in  input  5  destination register of the request.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rd_w  output  1  register-file write enable; drives the register file's rd_w directly.
REQ-012 rd_addr  output  5  latched destination register.
REQ-013 rd  output  32  result value.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE; after reset the FSM SHALL be in IDLE.
REQ-015 IDLE with start=1 SHALL latch funct3, rs1, rs2 and rd_addr_in at the edge (call it cycle 0).
- Next state SHALL be CALC, or DONE for the special cases in REQ-019/REQ-020.
REQ-016 Input changes after cycle 0 SHALL NOT affect the operation in progress.
REQ-017 CALC SHALL run exactly 32 radix-2 iterations: shift-add for multiply, restoring shift-subtract for divide.
- Timing: CALC occupies cycles 1..32, DONE is cycle 33, IDLE resumes at cycle 34.
REQ-018 Signed operands SHALL be converted to magnitudes before iterating and the sign fixed up in DONE.
- MULHSU: rs1 signed, rs2 unsigned.
- Multiply uses a full 64-bit product.
- MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
REQ-019 Divide by zero SHALL skip CALC and enter DONE in cycle 1.
- Quotient = 0xFFFFFFFF; remainder = dividend.
REQ-020 DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF SHALL skip CALC and enter DONE in cycle 1.
- Quotient = 0x80000000; remainder = 0.
REQ-021 Signed division SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and rd/rd_addr SHALL be valid in the same cycle.
REQ-023 rd_w SHALL equal done except when the latched rd_addr is 0, in which case rd_w SHALL stay 0.
- Reason: the register file does not hard-wire x0.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 start in the DONE cycle SHALL be ignored; a new request is accepted from the cycle where IDLE is entered.
REQ-026 rd and rd_addr SHALL hold their last values until the next DONE.
- Between DONE pulses they are not write-qualified.
REQ-027 busy SHALL rise in the cycle after start is accepted and fall in the cycle after DONE.

Reset
REQ-028 rst=0 SHALL immediately, with no clock edge needed, force the following:
- state = IDLE;
- busy = 0, done = 0, rd_w = 0;
- rd = 0, rd_addr = 0;
- all internal operand, accumulator and counter registers = 0.
REQ-029 Reset during CALC or DONE SHALL abort the operation with no rd_w pulse.
- After rst returns to 1, the next start SHALL be accepted normally.

Verification
REQ-030 MUL: rs1=7, rs2=0xFFFFFFFD, rd_addr_in=5.
- -> done, rd_w=1 in cycle 33, rd=0xFFFFFFEB, rd_addr=5; busy=1 in cycles 1..33.
REQ-031 High-half multiplies:
- MULH 0x80000000 x 0x80000000 -> rd=0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rd=0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> rd=0xFFFFFFFF.
REQ-032 Signed divide, rs1=0xFFFFFFF9 (-7), rs2=2:
- DIV -> rd=0xFFFFFFFD.
- REM -> rd=0xFFFFFFFF.
- DIVU 100/7 -> rd=14.
- REMU 100/7 -> rd=2.
REQ-033 Special cases, each with done in cycle 1:
- DIVU 5/0 -> rd=0xFFFFFFFF.
- REMU 5/0 -> rd=5.
- DIV 0x80000000/0xFFFFFFFF -> rd=0x80000000.
- REM 0x80000000/0xFFFFFFFF -> rd=0.
REQ-034 rd_addr_in=0 with MUL 3x4 -> done=1, rd=12, rd_w=0.
- A second start held high in cycles 1..33 produces no further done.
REQ-035 Reset mid-operation: rst=0 in cycle 10 of a DIV -> busy, done, rd_w and rd all 0 immediately; no rd_w pulse ever appears.
- After release, DIVU 9/3 -> rd=3 in cycle 33 of that new request.

Source files
------------

// File: rtl/muldiv.sv
// ---------------------------------------------------------------------------
// muldiv -- iterative RV32M multiply / divide unit.
//
// A request is accepted in IDLE when start is high. Operands are converted to
// magnitudes, then 32 radix-2 iterations run in CALC. Multiply uses shift-add
// into a 64-bit product. Divide uses restoring shift-subtract. The signed
// result is produced on the way into DONE. Divide-by-zero and the signed
// overflow case (0x80000000 / -1) go straight to DONE.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   start       request strobe, sampled only in IDLE
//   funct3      RV32M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1, rs2    operand A / dividend, operand B / divisor
//   rd_addr_in  destination register of the request
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   rd_w        register-file write enable (suppressed for x0)
//   rd_addr     destination register of the last completed operation
//   rd          result of the last completed operation
// ---------------------------------------------------------------------------
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd_addr_in,
  output logic        busy,
  output logic        done,
  output logic        rd_w,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      state_q,   state_d;
  logic [2:0]  op_q,      op_d;       // latched funct3
  logic [4:0]  dest_q,    dest_d;     // latched destination register
  logic        neg_q,     neg_d;      // final result must be negated
  logic [31:0] b_q,       b_d;        // multiplicand / divisor magnitude
  logic [63:0] acc_q,     acc_d;      // {hi, lo}: product or {remainder, quotient}
  logic [4:0]  cnt_q,     cnt_d;      // iteration counter
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        rd_w_q,    rd_w_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_q,      rd_d;

  // Request decode on the live inputs (only used in IDLE).
  logic        a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && rs1[31];
    b_neg    = b_signed && rs2[31];
    a_mag    = a_neg ? (~rs1 + 32'd1) : rs1;
    b_mag    = b_neg ? (~rs2 + 32'd1) : rs2;
    // Remainder takes the dividend's sign; everything else takes the XOR.
    res_neg  = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = funct3[2] && (rs2 == 32'd0);
    div_ovf  = funct3[2] && !funct3[0] &&
               (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    if (div_zero) begin
      special_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One radix-2 iteration of the latched operation.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_top, div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] iter_next;
  logic [63:0] mul_fix;
  logic [31:0] div_sel, div_fix;
  logic [31:0] final_res;

  always_comb begin
    // Shift-add: conditionally add the multiplicand into the high half,
    // then shift the whole 65-bit {carry, product} right by one.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide: shift {rem, quo} left, try to subtract the divisor
    // from the 33-bit partial remainder, and shift in the quotient bit.
    div_top  = acc_q[63:31];
    div_ge   = (div_top >= {1'b0, b_q});
    div_diff = div_top - {1'b0, b_q};
    div_next = {(div_ge ? div_diff[31:0] : div_top[31:0]), acc_q[30:0], div_ge};

    iter_next = op_q[2] ? div_next : mul_next;

    // Sign fix-up applied to the value after the last iteration.
    mul_fix   = neg_q ? (~iter_next + 64'd1) : iter_next;
    div_sel   = op_q[1] ? iter_next[63:32] : iter_next[31:0];
    div_fix   = neg_q ? (~div_sel + 32'd1) : div_sel;
    if (op_q[2]) begin
      final_res = div_fix;
    end else if (op_q[1:0] == 2'b00) begin
      final_res = mul_fix[31:0];
    end else begin
      final_res = mul_fix[63:32];
    end
  end

  // NOTE: every _d starts from its _q (or a pulse default) so no path through
  // this block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    neg_d     = neg_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_w_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = funct3;
          dest_d = rd_addr_in;
          neg_d  = res_neg;
          b_d    = b_mag;
          acc_d  = {32'd0, a_mag};
          cnt_d  = 5'd0;
          busy_d = 1'b1;
          if (div_zero || div_ovf) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            rd_w_d    = (rd_addr_in != 5'd0);
            rd_d      = special_res;
            rd_addr_d = rd_addr_in;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          rd_w_d    = (dest_q != 5'd0);
          rd_d      = final_res;
          rd_addr_d = dest_q;
        end
      end
      S_DONE: begin
        // A start seen here is dropped, not queued.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the operand and accumulator registers are reset too, so an abort
  // leaves no stale state behind and reset fully clears the datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      dest_q    <= 5'd0;
      neg_q     <= 1'b0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_w_q    <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_q      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      neg_q     <= neg_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_w_q    <= rd_w_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_w    = rd_w_q;
  assign rd_addr = rd_addr_q;
  assign rd      = rd_q;

endmodule

// File: tb/tb_muldiv.sv
// ---------------------------------------------------------------------------
// tb_muldiv -- directed self-checking bench for muldiv.
// Inputs are driven and outputs sampled on the falling clock edge. The cycle
// after the accepting rising edge is cycle 1.
// ---------------------------------------------------------------------------
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [4:0]  rd_addr_in = 5'd0;
  logic        busy, done, rd_w;
  logic [4:0]  rd_addr;
  logic [31:0] rd;

  int n_vec = 0;
  int n_bad = 0;

  muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd_addr_in (rd_addr_in),
    .busy       (busy),
    .done       (done),
    .rd_w       (rd_w),
    .rd_addr    (rd_addr),
    .rd         (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and check its completion. lat is the expected cycle of
  // done. With hold=1 start stays high through the whole operation.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] addr,
                        input logic [31:0] exp, input int lat, input bit hold);
    int k;
    int busy_low;
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; rd_addr_in = addr; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    // Scramble inputs: the operation in flight must not see them.
    rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom); rd_addr_in = 5'($urandom);
    k = 1;
    busy_low = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " rd"}, rd, exp);
    check({tag, " rd_addr"}, {27'd0, rd_addr}, {27'd0, addr});
    check({tag, " rd_w"}, {31'd0, rd_w}, {31'd0, (addr != 5'd0)});
    check({tag, " busy in DONE"}, {31'd0, busy}, 32'd1);
    check({tag, " busy low cycles"}, 32'(busy_low), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check({tag, " done cleared"}, {31'd0, done}, 32'd0);
    check({tag, " busy cleared"}, {31'd0, busy}, 32'd0);
    check({tag, " rd_w cleared"}, {31'd0, rd_w}, 32'd0);
    check({tag, " rd held"}, rd, exp);
  endtask

  initial begin
    int extra;
    // Reset state, before any clock edge.
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset rd_w", {31'd0, rd_w}, 32'd0);
    check("reset rd", rd, 32'd0);
    check("reset rd_addr", {27'd0, rd_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Multiply, low and high halves.
    run_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0);
    run_op("MUL 0x12345678*16", 3'b000, 32'h1234_5678, 32'd16,       5'd6,  32'h2345_6780, 33, 1'b0);
    run_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33, 1'b0);
    run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33, 1'b0);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33, 1'b0);

    // Divide and remainder.
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33, 1'b0);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33, 1'b0);
    run_op("DIVU 100/7",      3'b101, 32'd100,       32'd7,         5'd8,  32'd14,        33, 1'b0);
    run_op("REMU 100/7",      3'b111, 32'd100,       32'd7,         5'd9,  32'd2,         33, 1'b0);

    // Special cases finish in cycle 1.
    run_op("DIVU 5/0",        3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("REMU 5/0",        3'b111, 32'd5,         32'd0,         5'd11, 32'd5,         1, 1'b0);
    run_op("REM -7/0",        3'b110, 32'hFFFF_FFF9, 32'd0,         5'd12, 32'hFFFF_FFF9, 1, 1'b0);
    run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 1'b0);
    run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1, 1'b0);

    // x0 destination, start held high while busy: no write, no second done.
    run_op("MUL 3*4 x0",      3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        33, 1'b1);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("no queued start", 32'(extra), 32'd0);

    // Reset in cycle 10 of a DIV aborts it immediately.
    @(negedge clk);
    funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7; rd_addr_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-abort busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort rd_w", {31'd0, rd_w}, 32'd0);
    check("abort rd", rd, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd_w === 1'b1 || done === 1'b1) extra++;
    end
    check("no pulse after abort", 32'(extra), 32'd0);

    run_op("DIVU 9/3 after reset", 3'b101, 32'd9, 32'd3, 5'd15, 32'd3, 33, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
